// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S output controller.
package i2s_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int BITS_PER_CH = 16;
  localparam int FRAME_BITS  = 2 * BITS_PER_CH;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;
endpackage

// File: rtl/i2s_frame_fifo.sv
// Stereo frame buffer: power-of-two depth, first-word-fall-through read port.
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  frame_t     wr_data,
  output frame_t     rd_data,
  output logic [4:0] level,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  frame_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (level == 5'(DEPTH));
  assign empty   = (level == 5'd0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + {4'd0, push} - {4'd0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/i2s_ctrl.sv
// I2S transmit controller: Bclk/Wclk generation and per-frame sample scheduling.
module i2s_ctrl
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [SAMPLE_W-1:0] DLeft,
  output logic [SAMPLE_W-1:0] DRight,
  output logic                Bclk,
  output logic                Wclk,
  output logic [4:0]          fifo_level,
  output logic                underrun,
  output logic [7:0]          underrun_cnt,
  input  logic                clear_underrun
);
  localparam logic [7:0] DIV_TC  = 8'(BCLK_DIV - 1);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  logic [7:0] divider;
  logic [4:0] bit_cnt;
  logic [4:0] bit_cnt_nxt;
  logic       tc;
  logic       boundary;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  frame_t     wr_frame;
  frame_t     rd_frame;

  assign tc          = enable && (divider == DIV_TC);
  assign boundary    = tc && Bclk && (bit_cnt == LAST_BIT);
  assign bit_cnt_nxt = bit_cnt + 5'd1;
  assign in_ready    = !fifo_full;
  assign push        = in_valid && in_ready;
  assign pop         = boundary && !fifo_empty;
  assign wr_frame    = '{left: in_left, right: in_right};

  i2s_frame_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_data(wr_frame),
    .rd_data(rd_frame),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Bit and word clocks; Wclk only moves on a Bclk falling toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divider <= 8'd0;
      Bclk    <= 1'b0;
      bit_cnt <= 5'd0;
      Wclk    <= 1'b0;
    end else if (!enable) begin
      divider <= 8'd0;
      Bclk    <= 1'b0;
      bit_cnt <= 5'd0;
      Wclk    <= 1'b0;
    end else if (tc) begin
      divider <= 8'd0;
      Bclk    <= ~Bclk;
      if (Bclk) begin
        bit_cnt <= bit_cnt_nxt;
        Wclk    <= bit_cnt_nxt[4];
      end
    end else begin
      divider <= divider + 8'd1;
    end
  end

  // Sample registers and underrun accounting, updated on frame boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DLeft        <= '0;
      DRight       <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      underrun <= boundary && fifo_empty;
      if (boundary) begin
        if (fifo_empty) begin
          DLeft  <= '0;
          DRight <= '0;
        end else begin
          DLeft  <= rd_frame.left;
          DRight <= rd_frame.right;
        end
      end
      if (clear_underrun) begin
        underrun_cnt <= 8'd0;
      end else if (boundary && fifo_empty && (underrun_cnt != 8'hFF)) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_i2s_ctrl.sv
// Self-checking bench for i2s_ctrl against a cycle-count/queue reference model.
module tb_i2s_ctrl;
  localparam int BDIV       = 4;
  localparam int DEPTH      = 4;
  localparam int FRAME_CLKS = 64 * BDIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] DLeft;
  logic [15:0] DRight;
  logic        Bclk;
  logic        Wclk;
  logic [4:0]  fifo_level;
  logic        underrun;
  logic [7:0]  underrun_cnt;
  logic        clear_underrun;

  int compCount = 0;
  int failCount = 0;

  // Model: enabled-cycle count since enable rose, plus a frame queue.
  int          n;
  logic [31:0] q[$];
  logic [15:0] expL;
  logic [15:0] expR;
  int          expCnt;
  logic        expUnder;

  i2s_ctrl #(
    .BCLK_DIV  (BDIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .in_left       (in_left),
    .in_right      (in_right),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .DLeft         (DLeft),
    .DRight        (DRight),
    .Bclk          (Bclk),
    .Wclk          (Wclk),
    .fifo_level    (fifo_level),
    .underrun      (underrun),
    .underrun_cnt  (underrun_cnt),
    .clear_underrun(clear_underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("Bclk", {31'd0, Bclk}, 32'((n / BDIV) % 2));
    checkOutput("Wclk", {31'd0, Wclk}, 32'(((n / (2 * BDIV)) % 32) >= 16));
    checkOutput("fifo_level", {27'd0, fifo_level}, 32'(q.size()));
    checkOutput("in_ready", {31'd0, in_ready}, 32'(q.size() != DEPTH));
    checkOutput("DLeft", {16'd0, DLeft}, {16'd0, expL});
    checkOutput("DRight", {16'd0, DRight}, {16'd0, expR});
    checkOutput("underrun", {31'd0, underrun}, {31'd0, expUnder});
    checkOutput("underrun_cnt", {24'd0, underrun_cnt}, 32'(expCnt));
  endtask

  task automatic applyStimulus(input logic en, input logic vld, input logic [15:0] l,
                               input logic [15:0] r, input logic clr);
    logic        bnd;
    int          pre;
    logic [31:0] f;
    enable         = en;
    in_valid       = vld;
    in_left        = l;
    in_right       = r;
    clear_underrun = clr;
    @(posedge clk);
    pre      = q.size();
    bnd      = en && (((n + 1) % FRAME_CLKS) == 0);
    n        = en ? n + 1 : 0;
    expUnder = bnd && (pre == 0);
    if (bnd) begin
      if (pre > 0) begin
        f    = q.pop_front();
        expL = f[31:16];
        expR = f[15:0];
      end else begin
        expL = 16'd0;
        expR = 16'd0;
      end
    end
    if (vld && (pre < DEPTH)) q.push_back({l, r});
    if (clr) expCnt = 0;
    else if (expUnder && (expCnt < 255)) expCnt++;
    #1;
    checkAll();
  endtask

  task automatic resetMidCycle();
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    n        = 0;
    q.delete();
    expL     = 16'd0;
    expR     = 16'd0;
    expUnder = 1'b0;
    expCnt   = 0;
    checkAll();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic found;
    rst            = 1'b1;
    enable         = 1'b0;
    in_valid       = 1'b0;
    in_left        = 16'd0;
    in_right       = 16'd0;
    clear_underrun = 1'b0;
    n        = 0;
    expL     = 16'd0;
    expR     = 16'd0;
    expCnt   = 0;
    expUnder = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    rst = 1'b0;

    // Two frames queued while idle, then played out on consecutive boundaries.
    applyStimulus(1'b0, 1'b1, 16'h1234, 16'hABCD, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0001, 16'hFFFF, 1'b0);
    for (int i = 0; i < 2 * FRAME_CLKS + 2; i++)
      applyStimulus(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0);

    // Overfill: the fifth and sixth offers must be refused.
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b0);

    for (int i = 0; i < 2500; i++)
      applyStimulus(1'($urandom_range(0, 599) != 0), 1'($urandom_range(0, 15) == 0),
                    16'($urandom), 16'($urandom), 1'($urandom_range(0, 299) == 0));

    // Drop enable at bit 20 of the frame, then re-enable for a full frame.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
      applyStimulus(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0);
      if (((n / (2 * BDIV)) % 32) == 20) found = 1'b1;
    end
    checkOutput("bitcnt20_reached", {31'd0, found}, 32'd1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b0);
    for (int i = 0; i < FRAME_CLKS + 4; i++)
      applyStimulus(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0);

    // Reset mid-frame with three frames buffered.
    resetMidCycle();
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b0);
    for (int i = 0; i < 100; i++)
      applyStimulus(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0);
    resetMidCycle();

    // Starve the FIFO long enough to saturate the underrun counter.
    for (int i = 0; i < 258 * FRAME_CLKS; i++)
      applyStimulus(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0);
    for (int i = 0; i < FRAME_CLKS && (((n + 1) % FRAME_CLKS) != 0); i++)
      applyStimulus(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b1);
    for (int i = 0; i < FRAME_CLKS + 2; i++)
      applyStimulus(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end
endmodule
